axi_full_mst_line: RTL and testbench
====================================

Name: axi_full_mst_line

Overview:
- Cache-line AXI4 burst master; sits directly upstream of the testbench AXI SRAM slave and drives its MEM_* port.
- Converts one line-sized read or write request into a single INCR burst of BEATS beats.
- Returns the line data (read) or completion (write) on a response handshake.
- One transaction outstanding at a time; no AR/AW overlap.

Parameters:
- DW, 64, AXI data width in bits (power of 2, >= 32).
- BEATS, 4, beats per line (power of 2, 1..256); line width LW = DW*BEATS.
- ID, 4'd0, fixed value driven on MEM_AWID / MEM_ARID.

Ports:
- CLK  input  1  clock, all logic rising-edge.
- RST  input  1  synchronous, active-high reset.
- REQ_VALID / REQ_READY  input / output  1 / 1  request handshake.
- REQ_WEN  input  1  1 = write line, 0 = read line.
- REQ_ADDR  input  32  byte address; low log2(LW/8) bits ignored (forced 0).
- REQ_WDATA  input  LW  write line; beat k = REQ_WDATA[k*DW +: DW].
- RSP_VALID / RSP_READY  output / input  1 / 1  response handshake.
- RSP_RDATA  output  LW  read line (beat k at [k*DW +: DW]); holds last read line after writes.
- RSP_ERR  output  1  any non-OKAY resp or RLAST protocol mismatch in this transaction.
- MEM_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  output  4/32/8/3/2/1  AW channel.
- MEM_AWREADY  input  1.
- MEM_WDATA/WSTRB/WLAST/WVALID  output  DW/DW/8/1/1  W channel.
- MEM_WREADY  input  1.
- MEM_BID/BRESP/BVALID  input  4/2/1;  MEM_BREADY  output  1.
- MEM_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  output  4/32/8/3/2/1  AR channel.
- MEM_ARREADY  input  1.
- MEM_RID/RDATA/RRESP/RLAST/RVALID  input  4/DW/2/1/1;  MEM_RREADY  output  1.

Behaviour:
- States: IDLE, AR, R, AW, W, B, RSP. Reset (RST=1 at an edge) -> IDLE, beat counter 0, err 0, RSP_RDATA 0; all VALID/READY outputs 0 except REQ_READY=1.
- RST mid-transaction aborts immediately to IDLE with all valids dropped; the bench resets the slave in the same cycle.
- IDLE: REQ_READY=1. On REQ_VALID, latch line address and WDATA, clear err and counter; go to AW if REQ_WEN, else AR. Earliest ARVALID/AWVALID is the cycle after acceptance.
- Address/control on AR and AW are constant while VALID:
  - ADDR = line address.
  - LEN = BEATS-1.
  - SIZE = log2(DW/8).
  - BURST = 2'b01.
  - ID = ID.
- AR: ARVALID=1 until ARREADY, then R.
- R: RREADY=1. Each RVALID&RREADY stores RDATA at beat cnt and increments cnt.
  - RRESP != 0 sets err.
  - RLAST must equal (cnt==BEATS-1); a mismatch sets err.
  - Exit to RSP on the beat where cnt==BEATS-1. Beats after that are not accepted.
- AW: AWVALID=1 until AWREADY, then W. W is never driven before the AW handshake; the slave asserts WREADY only after its AW flag.
- W: WVALID=1, WDATA = latched beat cnt, WSTRB all ones, WLAST = (cnt==BEATS-1).
  - cnt advances on WVALID&WREADY.
  - After the last-beat handshake, WVALID drops the next cycle -> B.
- B: BREADY=1. On BVALID, BRESP != 0 sets err -> RSP. BID/RID are not checked.
- RSP: RSP_VALID=1 with RSP_RDATA/RSP_ERR stable until RSP_READY, then IDLE. A new request can be accepted no earlier than the cycle after the RSP handshake.
- Counter is log2(BEATS) bits wide, at least 1 bit; it wraps to 0 at exit from R and from W.
- BEATS=1: a single beat with LAST=1 on the first beat.

Test Plan:
- Read, DW=64, BEATS=4: slave preloaded with words 0x1111..0x4444 at 0x100..0x118. REQ_ADDR=0x104, read -> ARADDR=0x100, ARLEN=3, ARSIZE=3, ARBURST=1; RSP_RDATA={0x4444,0x3333,0x2222,0x1111}; RSP_ERR=0.
- Write then read of the line at 0x200 with REQ_WDATA beats A0..A3 -> four W beats, WLAST only on the fourth, WSTRB=0xFF, BRESP=0, RSP_ERR=0; the follow-up read returns A0..A3.
- Backpressure: RREADY held by the master, slave RVALID randomly gapped, RSP_READY low for 5 cycles -> RSP_VALID and RSP_RDATA stable across all 5 cycles; no beat lost or duplicated.
- Error injection:
  - RRESP=2'b10 on beat 2 -> RSP_ERR=1.
  - RLAST asserted on beat 1 -> RSP_ERR=1, and still 4 beats are consumed.
  - BRESP=2'b10 -> RSP_ERR=1.
- Reset mid-W after 2 beats -> next cycle: all valids 0, REQ_READY=1; a subsequent read completes normally.
- Back-to-back requests with REQ_VALID held high -> second ARVALID no earlier than 2 cycles after the first RSP handshake; AR and AW never overlap.

Source files
------------

// File: rtl/axi_full_mst_line_if.sv
// AXI4 memory-side bundle between the cache-line master and the SRAM slave.
interface axi_full_mst_line_if #(
  parameter int DW = 64
);
  logic [3:0]      MEM_AWID;
  logic [31:0]     MEM_AWADDR;
  logic [7:0]      MEM_AWLEN;
  logic [2:0]      MEM_AWSIZE;
  logic [1:0]      MEM_AWBURST;
  logic            MEM_AWVALID;
  logic            MEM_AWREADY;
  logic [DW-1:0]   MEM_WDATA;
  logic [DW/8-1:0] MEM_WSTRB;
  logic            MEM_WLAST;
  logic            MEM_WVALID;
  logic            MEM_WREADY;
  logic [3:0]      MEM_BID;
  logic [1:0]      MEM_BRESP;
  logic            MEM_BVALID;
  logic            MEM_BREADY;
  logic [3:0]      MEM_ARID;
  logic [31:0]     MEM_ARADDR;
  logic [7:0]      MEM_ARLEN;
  logic [2:0]      MEM_ARSIZE;
  logic [1:0]      MEM_ARBURST;
  logic            MEM_ARVALID;
  logic            MEM_ARREADY;
  logic [3:0]      MEM_RID;
  logic [DW-1:0]   MEM_RDATA;
  logic [1:0]      MEM_RRESP;
  logic            MEM_RLAST;
  logic            MEM_RVALID;
  logic            MEM_RREADY;

  modport master (
    output MEM_AWID, MEM_AWADDR, MEM_AWLEN, MEM_AWSIZE, MEM_AWBURST, MEM_AWVALID,
    input  MEM_AWREADY,
    output MEM_WDATA, MEM_WSTRB, MEM_WLAST, MEM_WVALID,
    input  MEM_WREADY,
    input  MEM_BID, MEM_BRESP, MEM_BVALID,
    output MEM_BREADY,
    output MEM_ARID, MEM_ARADDR, MEM_ARLEN, MEM_ARSIZE, MEM_ARBURST, MEM_ARVALID,
    input  MEM_ARREADY,
    input  MEM_RID, MEM_RDATA, MEM_RRESP, MEM_RLAST, MEM_RVALID,
    output MEM_RREADY
  );

  modport slave (
    input  MEM_AWID, MEM_AWADDR, MEM_AWLEN, MEM_AWSIZE, MEM_AWBURST, MEM_AWVALID,
    output MEM_AWREADY,
    input  MEM_WDATA, MEM_WSTRB, MEM_WLAST, MEM_WVALID,
    output MEM_WREADY,
    output MEM_BID, MEM_BRESP, MEM_BVALID,
    input  MEM_BREADY,
    input  MEM_ARID, MEM_ARADDR, MEM_ARLEN, MEM_ARSIZE, MEM_ARBURST, MEM_ARVALID,
    output MEM_ARREADY,
    output MEM_RID, MEM_RDATA, MEM_RRESP, MEM_RLAST, MEM_RVALID,
    input  MEM_RREADY
  );
endinterface

// File: rtl/axi_full_mst_line.sv
// Cache-line AXI4 master: turns one line read/write request into a single
// INCR burst of BEATS beats and returns the line / completion on a response.
module axi_full_mst_line #(
  parameter int         DW    = 64,
  parameter int         BEATS = 4,
  parameter logic [3:0] ID    = 4'd0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WEN,
  input  logic [31:0]           REQ_ADDR,
  input  logic [DW*BEATS-1:0]   REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DW*BEATS-1:0]   RSP_RDATA,
  output logic                  RSP_ERR,
  axi_full_mst_line_if.master   mem
);

  localparam int          LW        = DW * BEATS;
  localparam int          CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [31:0] LINE_MASK = ~32'(LW/8 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RSP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [31:0]     addr_q, addr_d;
  logic [LW-1:0]   wdata_q, wdata_d;
  logic [LW-1:0]   rdata_q, rdata_d;
  logic            last_beat;
  logic            unused_ids;

  assign last_beat  = (cnt_q == CW'(BEATS - 1));
  assign unused_ids = ^{mem.MEM_BID, mem.MEM_RID};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          addr_d  = REQ_ADDR & LINE_MASK;
          wdata_d = REQ_WDATA;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = REQ_WEN ? S_AW : S_AR;
        end
      end
      S_AR: if (mem.MEM_ARREADY) state_d = S_R;
      S_R: begin
        // RLAST is checked against our own beat count, so an early or missing
        // RLAST is flagged but the burst still runs its full length.
        if (mem.MEM_RVALID) begin
          rdata_d[int'(cnt_q)*DW +: DW] = mem.MEM_RDATA;
          if (mem.MEM_RRESP != 2'b00)     err_d = 1'b1;
          if (mem.MEM_RLAST != last_beat) err_d = 1'b1;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_RSP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_AW: if (mem.MEM_AWREADY) state_d = S_W;
      S_W: begin
        if (mem.MEM_WREADY) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_B;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_B: begin
        if (mem.MEM_BVALID) begin
          if (mem.MEM_BRESP != 2'b00) err_d = 1'b1;
          state_d = S_RSP;
        end
      end
      S_RSP: if (RSP_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign REQ_READY = (state_q == S_IDLE);
  assign RSP_VALID = (state_q == S_RSP);
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = err_q;

  assign mem.MEM_ARID    = ID;
  assign mem.MEM_ARADDR  = addr_q;
  assign mem.MEM_ARLEN   = 8'(BEATS - 1);
  assign mem.MEM_ARSIZE  = 3'($clog2(DW/8));
  assign mem.MEM_ARBURST = 2'b01;
  assign mem.MEM_ARVALID = (state_q == S_AR);
  assign mem.MEM_RREADY  = (state_q == S_R);

  assign mem.MEM_AWID    = ID;
  assign mem.MEM_AWADDR  = addr_q;
  assign mem.MEM_AWLEN   = 8'(BEATS - 1);
  assign mem.MEM_AWSIZE  = 3'($clog2(DW/8));
  assign mem.MEM_AWBURST = 2'b01;
  assign mem.MEM_AWVALID = (state_q == S_AW);

  assign mem.MEM_WDATA   = wdata_q[int'(cnt_q)*DW +: DW];
  assign mem.MEM_WSTRB   = '1;
  assign mem.MEM_WLAST   = last_beat;
  assign mem.MEM_WVALID  = (state_q == S_W);
  assign mem.MEM_BREADY  = (state_q == S_B);

endmodule

// File: tb/tb_axi_full_mst_line.sv
// Directed bench for axi_full_mst_line with a small AXI SRAM slave model,
// a response scoreboard and bus monitors built on immediate assertions.
module tb_axi_full_mst_line;

  localparam int DW    = 64;
  localparam int BEATS = 4;
  localparam int LW    = DW * BEATS;

  typedef struct packed { logic [LW-1:0] rdata; logic err; } rsp_t;
  typedef struct packed { logic wen; logic [31:0] addr; } addr_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } wbeat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_wen;
  logic [31:0]   req_addr;
  logic [LW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [LW-1:0] rsp_rdata;

  axi_full_mst_line_if #(.DW(DW)) mem_if ();

  axi_full_mst_line #(.DW(DW), .BEATS(BEATS), .ID(4'd0)) dut (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WEN(req_wen),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
    .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .mem(mem_if)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int w_hs     = 0;
  int rsp_cyc  = 0;
  bit have_rsp = 0;
  bit ar_prev  = 0;
  bit aw_prev  = 0;

  rsp_t   sb[$];
  addr_t  addr_q[$];
  wbeat_t w_q[$];

  // Slave model: 256-word SRAM, one burst at a time, with fault injection knobs.
  logic [63:0] sram [0:255];
  logic        aw_got, b_pend, r_active, r_ok;
  logic [7:0]  w_idx, r_idx, r_cnt, r_len;
  int          inj_rresp_beat = -1;
  int          inj_rlast_beat = -1;
  logic        inj_bresp = 1'b0;
  logic        gap_en    = 1'b0;

  assign mem_if.MEM_AWREADY = !aw_got && !b_pend;
  assign mem_if.MEM_WREADY  = aw_got;
  assign mem_if.MEM_BVALID  = b_pend;
  assign mem_if.MEM_BRESP   = inj_bresp ? 2'b10 : 2'b00;
  assign mem_if.MEM_BID     = 4'd0;
  assign mem_if.MEM_ARREADY = !r_active;
  assign mem_if.MEM_RVALID  = r_active && r_ok;
  assign mem_if.MEM_RDATA   = sram[r_idx + r_cnt];
  assign mem_if.MEM_RRESP   = (int'(r_cnt) == inj_rresp_beat) ? 2'b10 : 2'b00;
  assign mem_if.MEM_RLAST   = (r_cnt == r_len) || (int'(r_cnt) == inj_rlast_beat);
  assign mem_if.MEM_RID     = 4'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      aw_got   <= 1'b0;
      b_pend   <= 1'b0;
      w_idx    <= 8'd0;
      r_active <= 1'b0;
      r_idx    <= 8'd0;
      r_cnt    <= 8'd0;
      r_len    <= 8'd0;
      r_ok     <= 1'b1;
      sram[32] <= 64'h1111;
      sram[33] <= 64'h2222;
      sram[34] <= 64'h3333;
      sram[35] <= 64'h4444;
    end else begin
      if (mem_if.MEM_AWVALID && mem_if.MEM_AWREADY) begin
        aw_got <= 1'b1;
        w_idx  <= mem_if.MEM_AWADDR[10:3];
      end
      if (mem_if.MEM_WVALID && mem_if.MEM_WREADY) begin
        sram[w_idx] <= mem_if.MEM_WDATA;
        w_idx       <= w_idx + 8'd1;
        if (mem_if.MEM_WLAST) begin
          aw_got <= 1'b0;
          b_pend <= 1'b1;
        end
      end
      if (mem_if.MEM_BVALID && mem_if.MEM_BREADY) b_pend <= 1'b0;
      if (mem_if.MEM_ARVALID && mem_if.MEM_ARREADY) begin
        r_active <= 1'b1;
        r_idx    <= mem_if.MEM_ARADDR[10:3];
        r_cnt    <= 8'd0;
        r_len    <= mem_if.MEM_ARLEN;
      end
      if (mem_if.MEM_RVALID && mem_if.MEM_RREADY) begin
        r_cnt <= r_cnt + 8'd1;
        if (r_cnt == r_len) r_active <= 1'b0;
      end
      r_ok <= (mem_if.MEM_RVALID && !mem_if.MEM_RREADY) ? 1'b1 :
              (gap_en ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    n_checks++;
    n_fails++;
    $error("[TB] FAIL %s: observed timeout/unexpected event, expected handshake", tag);
  endtask

  // Bus monitors: address phases, W beats, response pops and ordering rules.
  always @(negedge clk) begin
    addr_t  a;
    wbeat_t wb;
    rsp_t   r;
    if (!rst) begin
      if (mem_if.MEM_ARVALID || mem_if.MEM_AWVALID)
        check("ar_aw_overlap", mem_if.MEM_ARVALID && mem_if.MEM_AWVALID, 1'b0);
      if (mem_if.MEM_WVALID) check("w_after_aw", aw_got, 1'b1);
      if (mem_if.MEM_ARVALID && !ar_prev && have_rsp) check("ar_gap", (cyc - rsp_cyc) >= 2, 1'b1);
      if (mem_if.MEM_AWVALID && !aw_prev && have_rsp) check("aw_gap", (cyc - rsp_cyc) >= 2, 1'b1);

      if (mem_if.MEM_ARVALID && mem_if.MEM_ARREADY) begin
        if (addr_q.size() == 0) fail("ar_unexpected");
        else begin
          a = addr_q.pop_front();
          check("ar_kind",  a.wen, 1'b0);
          check("ar_addr",  mem_if.MEM_ARADDR, a.addr);
          check("ar_len",   mem_if.MEM_ARLEN, 8'd3);
          check("ar_size",  mem_if.MEM_ARSIZE, 3'd3);
          check("ar_burst", mem_if.MEM_ARBURST, 2'b01);
          check("ar_id",    mem_if.MEM_ARID, 4'd0);
        end
      end
      if (mem_if.MEM_AWVALID && mem_if.MEM_AWREADY) begin
        if (addr_q.size() == 0) fail("aw_unexpected");
        else begin
          a = addr_q.pop_front();
          check("aw_kind",  a.wen, 1'b1);
          check("aw_addr",  mem_if.MEM_AWADDR, a.addr);
          check("aw_len",   mem_if.MEM_AWLEN, 8'd3);
          check("aw_size",  mem_if.MEM_AWSIZE, 3'd3);
          check("aw_burst", mem_if.MEM_AWBURST, 2'b01);
          check("aw_id",    mem_if.MEM_AWID, 4'd0);
        end
      end
      if (mem_if.MEM_WVALID && mem_if.MEM_WREADY) begin
        w_hs++;
        if (w_q.size() == 0) fail("w_unexpected");
        else begin
          wb = w_q.pop_front();
          check("w_data", mem_if.MEM_WDATA, wb.data);
          check("w_last", mem_if.MEM_WLAST, wb.last);
          check("w_strb", mem_if.MEM_WSTRB, 8'hFF);
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cyc  = cyc;
        have_rsp = 1'b1;
        if (sb.size() == 0) fail("rsp_unexpected");
        else begin
          r = sb.pop_front();
          check("rsp_rdata", rsp_rdata, r.rdata);
          check("rsp_err",   rsp_err, r.err);
        end
      end
    end
    ar_prev = mem_if.MEM_ARVALID;
    aw_prev = mem_if.MEM_AWVALID;
  end

  logic [LW-1:0] last_read = '0;

  task automatic apply_stimulus(input logic wen, input logic [31:0] addr,
                                input logic [LW-1:0] wdata, input logic [LW-1:0] exp_line,
                                input logic exp_err, input bit keep);
    bit     hs = 0;
    int     n  = 0;
    addr_t  a;
    wbeat_t wb;
    rsp_t   r;
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    while (!hs && n < 300) begin
      @(negedge clk);
      hs = req_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!hs) fail("req_accept_timeout");
    else begin
      a.wen  = wen;
      a.addr = addr & 32'hFFFF_FFE0;
      addr_q.push_back(a);
      if (wen) begin
        for (int k = 0; k < BEATS; k++) begin
          wb.data = wdata[k*DW +: DW];
          wb.last = (k == BEATS - 1);
          w_q.push_back(wb);
        end
        r.rdata = last_read;
      end else begin
        r.rdata   = exp_line;
        last_read = exp_line;
      end
      r.err = exp_err;
      sb.push_back(r);
    end
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      fail("drain_timeout");
      sb.delete();
      addr_q.delete();
      w_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_output(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b1);
    check({tag, "_arvalid"},   mem_if.MEM_ARVALID, 1'b0);
    check({tag, "_awvalid"},   mem_if.MEM_AWVALID, 1'b0);
    check({tag, "_wvalid"},    mem_if.MEM_WVALID, 1'b0);
    check({tag, "_rready"},    mem_if.MEM_RREADY, 1'b0);
    check({tag, "_bready"},    mem_if.MEM_BREADY, 1'b0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
  endtask

  logic [LW-1:0] line_a, line_w, line_w2;
  int            base;
  bit            seen;

  initial begin
    line_a  = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
    line_w  = {64'hA3A3_0000_0000_00A3, 64'hA2A2_0000_0000_00A2,
               64'hA1A1_0000_0000_00A1, 64'hA0A0_0000_0000_00A0};
    line_w2 = {64'hB3B3_B3B3_0000_0003, 64'hB2B2_B2B2_0000_0002,
               64'hB1B1_B1B1_0000_0001, 64'hB0B0_B0B0_0000_0000};
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset");
    check("reset_rdata", rsp_rdata, '0);
    check("reset_err",   rsp_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] read of preloaded line");
    apply_stimulus(1'b0, 32'h104, '0, line_a, 1'b0, 1'b0);
    wait_drain();

    $display("[TB] write then read back line 0x200");
    apply_stimulus(1'b1, 32'h21C, line_w, '0, 1'b0, 1'b0);
    wait_drain();
    apply_stimulus(1'b0, 32'h200, '0, line_w, 1'b0, 1'b0);
    wait_drain();

    $display("[TB] gapped RVALID with response backpressure");
    rsp_ready = 1'b0;
    gap_en    = 1'b1;
    apply_stimulus(1'b0, 32'h110, '0, line_a, 1'b0, 1'b0);
    seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    if (!seen) fail("bp_rsp_timeout");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_rdata", rsp_rdata, line_a);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_drain();
    gap_en = 1'b0;

    $display("[TB] error injection");
    inj_rresp_beat = 2;
    apply_stimulus(1'b0, 32'h100, '0, line_a, 1'b1, 1'b0);
    wait_drain();
    inj_rresp_beat = -1;
    inj_rlast_beat = 1;
    apply_stimulus(1'b0, 32'h100, '0, line_a, 1'b1, 1'b0);
    wait_drain();
    inj_rlast_beat = -1;
    inj_bresp = 1'b1;
    apply_stimulus(1'b1, 32'h300, line_w2, '0, 1'b1, 1'b0);
    wait_drain();
    inj_bresp = 1'b0;

    $display("[TB] back-to-back requests with REQ_VALID held");
    apply_stimulus(1'b0, 32'h100, '0, line_a, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'h200, '0, line_w, 1'b0, 1'b0);
    wait_drain();

    $display("[TB] reset in the middle of a write burst");
    base = w_hs;
    apply_stimulus(1'b1, 32'h400, line_w2, '0, 1'b0, 1'b0);
    seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(posedge clk); #1;
      seen = (w_hs == base + 2);
    end
    if (!seen) fail("mid_w_timeout");
    rst = 1'b1;
    sb.delete();
    addr_q.delete();
    w_q.delete();
    last_read = '0;
    @(negedge clk);
    @(negedge clk);
    check_output("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    apply_stimulus(1'b0, 32'h118, '0, line_a, 1'b0, 1'b0);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
